// File: rtl/serial_deserializer16.sv
// serial_deserializer16: one-bit-per-handshake receiver assembling WIDTH-bit words onto a valid/ready output.
module serial_deserializer16 #(
  parameter int WIDTH     = 16,
  parameter int CNT_W     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sin,
  input  logic             i_sin_valid,
  output logic             o_sin_ready,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_pout,
  output logic             o_pout_valid,
  input  logic             i_pout_ready,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic             o_busy
);
  typedef enum logic {COLLECT, FULL} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_idx;
  logic             w_accept;
  logic             w_free;
  logic             w_last;
  logic             w_drain;
  assign o_sin_ready = i_rst_n & (r_state == COLLECT);
  assign w_accept    = i_sin_valid & o_sin_ready & ~i_flush;
  assign w_free      = ~o_pout_valid | i_pout_ready;
  assign w_last      = w_accept & (o_bit_cnt == CNT_W'(WIDTH - 1));
  assign w_drain     = (r_state == FULL) & w_free & ~i_flush;
  assign w_idx       = (MSB_FIRST != 0) ? CNT_W'(WIDTH - 1) - o_bit_cnt : o_bit_cnt;
  assign o_busy      = (o_bit_cnt != '0) | (r_state == FULL);
  always_comb begin
    w_acc_nxt        = r_acc;
    w_acc_nxt[w_idx] = i_sin;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= COLLECT;
      o_bit_cnt    <= '0;
      r_acc        <= '0;
      o_pout       <= '0;
      o_pout_valid <= 1'b0;
    end else begin
      if (i_flush) begin
        r_state   <= COLLECT;
        o_bit_cnt <= '0;
        r_acc     <= '0;
      end else if (w_drain) begin
        r_state <= COLLECT;
        r_acc   <= '0;
      end else if (w_accept) begin
        o_bit_cnt <= w_last ? '0 : o_bit_cnt + 1'b1;
        r_acc     <= (w_last & w_free) ? '0 : w_acc_nxt;
        if (w_last & ~w_free) r_state <= FULL;
      end
      // a new word loading in the same cycle as a handshake keeps pout_valid high
      if (w_drain | (w_last & w_free)) begin
        o_pout       <= w_drain ? r_acc : w_acc_nxt;
        o_pout_valid <= 1'b1;
      end else if (i_pout_ready) begin
        o_pout_valid <= 1'b0;
      end
    end
  end
endmodule
